// File: rtl/ps2_rx.sv
// PS/2 device-to-host receiver: synchronizes and de-glitches the PS/2 clock,
// deserializes 11-bit frames with odd parity, and buffers good bytes in a small FIFO.
module ps2_rx #(
    parameter int FILTER_LEN = 8,
    parameter int TIMEOUT    = 10000,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic       PS2_CLK,
    input  logic       PS2_DAT,
    output logic [7:0] code,
    output logic       code_valid,
    input  logic       code_ready,
    output logic       parity_err,
    output logic       frame_err,
    output logic       overflow,
    output logic       busy
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [FW-1:0] FILT_LAST = FW'(FILTER_LEN - 1);
    localparam logic [FW-1:0] FILT_ONE  = FW'(1);
    localparam logic [FW-1:0] FILT_ZERO = FW'(0);
    localparam logic [TW-1:0] TOUT_LAST = TW'(TIMEOUT - 1);
    localparam logic [TW-1:0] TOUT_ONE  = TW'(1);
    localparam logic [TW-1:0] TOUT_ZERO = TW'(0);
    localparam logic [AW:0]   PTR_ONE   = (AW + 1)'(1);
    localparam logic [AW:0]   PTR_ZERO  = (AW + 1)'(0);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } state_t;

    // Odd parity holds when the 8 data bits plus the parity bit contain an odd number of ones.
    function automatic logic odd_parity_ok(input logic [8:0] bits);
        return ^bits;
    endfunction

    logic [1:0]    clk_sync_r;
    logic [1:0]    dat_sync_r;
    logic          filt_clk_r;
    logic [FW-1:0] filt_cnt_r;
    logic [TW-1:0] tout_cnt_r;
    logic [7:0]    shift_r;
    logic [2:0]    bit_cnt_r;
    logic          par_r;
    state_t        state_r;
    state_t        state_s;
    logic [7:0]    mem_r [FIFO_DEPTH];
    logic [AW:0]   wr_ptr_r;
    logic [AW:0]   rd_ptr_r;

    logic differ_s;
    logic flip_s;
    logic fall_s;
    logic dat_s;
    logic tout_s;
    logic push_s;
    logic perr_s;
    logic ferr_s;
    logic empty_s;
    logic full_s;
    logic pop_s;
    logic wr_en_s;
    logic ovf_s;

    // Two-flop synchronizers for both PS/2 lines, idling high.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            clk_sync_r <= 2'b11;
            dat_sync_r <= 2'b11;
        end else begin
            clk_sync_r <= {clk_sync_r[0], PS2_CLK};
            dat_sync_r <= {dat_sync_r[0], PS2_DAT};
        end
    end

    assign dat_s    = dat_sync_r[1];
    assign differ_s = (clk_sync_r[1] != filt_clk_r);
    assign flip_s   = differ_s && (filt_cnt_r == FILT_LAST);
    assign fall_s   = flip_s && filt_clk_r;

    // Glitch filter: the filtered clock follows only after FILTER_LEN consecutive differing samples.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            filt_clk_r <= 1'b1;
            filt_cnt_r <= FILT_ZERO;
        end else if (flip_s) begin
            filt_clk_r <= ~filt_clk_r;
            filt_cnt_r <= FILT_ZERO;
        end else if (differ_s) begin
            filt_cnt_r <= filt_cnt_r + FILT_ONE;
        end else begin
            filt_cnt_r <= FILT_ZERO;
        end
    end

    // An accepted edge in the same cycle as expiry wins over the timeout.
    assign tout_s = (state_r != IDLE) && !fall_s && (tout_cnt_r == TOUT_LAST);

    // Mid-frame inactivity counter.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            tout_cnt_r <= TOUT_ZERO;
        end else if ((state_r == IDLE) || fall_s || tout_s) begin
            tout_cnt_r <= TOUT_ZERO;
        end else begin
            tout_cnt_r <= tout_cnt_r + TOUT_ONE;
        end
    end

    // Receiver state register.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state and per-frame verdict decode.
    always_comb begin
        state_s = state_r;
        push_s  = 1'b0;
        perr_s  = 1'b0;
        ferr_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (fall_s && !dat_s) begin
                    state_s = DATA;
                end else begin
                    state_s = IDLE;
                end
            end
            DATA: begin
                if (fall_s && (bit_cnt_r == 3'd7)) begin
                    state_s = PARITY;
                end else if (tout_s) begin
                    state_s = IDLE;
                    ferr_s  = 1'b1;
                end else begin
                    state_s = DATA;
                end
            end
            PARITY: begin
                if (fall_s) begin
                    state_s = STOP;
                end else if (tout_s) begin
                    state_s = IDLE;
                    ferr_s  = 1'b1;
                end else begin
                    state_s = PARITY;
                end
            end
            STOP: begin
                if (fall_s) begin
                    state_s = IDLE;
                    if (!dat_s) begin
                        ferr_s = 1'b1;
                    end else if (odd_parity_ok({par_r, shift_r})) begin
                        push_s = 1'b1;
                    end else begin
                        perr_s = 1'b1;
                    end
                end else if (tout_s) begin
                    state_s = IDLE;
                    ferr_s  = 1'b1;
                end else begin
                    state_s = STOP;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Deserializer: data arrives LSB first, so shift in from the top.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            shift_r   <= 8'h00;
            bit_cnt_r <= 3'd0;
            par_r     <= 1'b0;
        end else begin
            if ((state_r == DATA) && fall_s) begin
                shift_r <= {dat_s, shift_r[7:1]};
            end
            if (state_r == IDLE) begin
                bit_cnt_r <= 3'd0;
            end else if ((state_r == DATA) && fall_s) begin
                bit_cnt_r <= bit_cnt_r + 3'd1;
            end
            if ((state_r == PARITY) && fall_s) begin
                par_r <= dat_s;
            end
        end
    end

    // Pop is only possible when non-empty, so a push into an empty FIFO is never popped at once.
    assign empty_s = (wr_ptr_r == rd_ptr_r);
    assign full_s  = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    assign pop_s   = !empty_s && code_ready;
    assign wr_en_s = push_s && (!full_s || pop_s);
    assign ovf_s   = push_s && full_s && !pop_s;

    // FIFO storage and pointers.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            wr_ptr_r <= PTR_ZERO;
            rd_ptr_r <= PTR_ZERO;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_r[i] <= 8'h00;
            end
        end else begin
            if (wr_en_s) begin
                mem_r[wr_ptr_r[AW-1:0]] <= shift_r;
                wr_ptr_r                <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
        end
    end

    // Registered one-cycle status pulses.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            parity_err <= perr_s;
            frame_err  <= ferr_s;
            overflow   <= ovf_s;
        end
    end

    assign code       = mem_r[rd_ptr_r[AW-1:0]];
    assign code_valid = !empty_s;
    assign busy       = (state_r != IDLE);

endmodule

// File: tb/tb_ps2_rx.sv
// Self-checking bench for ps2_rx: table-driven frames plus hand-written latency,
// overflow, timeout, glitch and mid-frame reset sequences, with a byte scoreboard.
module tb_ps2_rx;

    localparam int FILTER_LEN = 8;
    localparam int TIMEOUT    = 2000;
    localparam int FIFO_DEPTH = 4;
    localparam int HALF       = 30;

    logic       clk = 1'b0;
    logic       reset;
    logic       ps2_clk;
    logic       ps2_dat;
    logic [7:0] code;
    logic       code_valid;
    logic       code_ready;
    logic       parity_err;
    logic       frame_err;
    logic       overflow;
    logic       busy;

    int total = 0;
    int bad   = 0;
    int perr_cnt = 0;
    int ferr_cnt = 0;
    int ovf_cnt  = 0;
    logic [7:0] exp_q [$];

    ps2_rx #(.FILTER_LEN(FILTER_LEN), .TIMEOUT(TIMEOUT), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .CLOCK_50  (clk),
        .reset     (reset),
        .PS2_CLK   (ps2_clk),
        .PS2_DAT   (ps2_dat),
        .code      (code),
        .code_valid(code_valid),
        .code_ready(code_ready),
        .parity_err(parity_err),
        .frame_err (frame_err),
        .overflow  (overflow),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        bit         bad_par;
        bit         bad_stop;
        int         exp_perr;
        int         exp_ferr;
        bit         exp_good;
    } vec_t;

    task automatic check(input string nm, input longint act, input longint exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [10:0] mk_frame(input logic [7:0] d, input bit bad_par, input bit bad_stop);
        logic p;
        p = ~(^d);
        if (bad_par) p = ~p;
        return {~bad_stop, p, d, 1'b0};
    endfunction

    task automatic send_bit(input logic b);
        @(negedge clk);
        ps2_dat = b;
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b0;
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b1;
    endtask

    task automatic send_bits(input logic [10:0] f, input int n);
        for (int i = 0; i < n; i++) send_bit(f[i]);
    endtask

    task automatic drain(input string nm);
        int n = 0;
        while (exp_q.size() != 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        check(nm, exp_q.size(), 0);
    endtask

    // Output monitor: pops the scoreboard on every handshake and tallies error pulses.
    always @(negedge clk) begin
        if (!reset) begin
            if (parity_err) perr_cnt++;
            if (frame_err)  ferr_cnt++;
            if (overflow)   ovf_cnt++;
            if (parity_err || frame_err || overflow)
                check("pulse_exclusive", int'(parity_err) + int'(frame_err) + int'(overflow), 1);
            if (code_valid && code_ready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_code actual=%0h required=none", code);
                end else begin
                    check("code", code, exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        vec_t vecs [8];
        int p0, f0, o0;
        logic busy_seen;
        int n;

        vecs[0] = '{8'h1C, 1'b0, 1'b0, 0, 0, 1'b1};
        vecs[1] = '{8'hF0, 1'b1, 1'b0, 1, 0, 1'b0};
        vecs[2] = '{8'hAA, 1'b0, 1'b0, 0, 0, 1'b1};
        vecs[3] = '{8'h55, 1'b0, 1'b1, 0, 1, 1'b0};
        vecs[4] = '{8'h00, 1'b0, 1'b0, 0, 0, 1'b1};
        vecs[5] = '{8'hFF, 1'b1, 1'b0, 1, 0, 1'b0};
        vecs[6] = '{8'h80, 1'b1, 1'b1, 0, 1, 1'b0};
        vecs[7] = '{8'h7E, 1'b0, 1'b0, 0, 0, 1'b1};

        reset = 1'b1; ps2_clk = 1'b1; ps2_dat = 1'b1; code_ready = 1'b1;
        repeat (4) @(negedge clk);
        check("rst_code", code, 8'h00);
        check("rst_valid", code_valid, 1'b0);
        check("rst_perr", parity_err, 1'b0);
        check("rst_ferr", frame_err, 1'b0);
        check("rst_ovf", overflow, 1'b0);
        check("rst_busy", busy, 1'b0);
        reset = 1'b0;
        repeat (5) @(negedge clk);

        // Latency: 2 sync stages + FILTER_LEN samples to detect, then one cycle to appear.
        p0 = perr_cnt; f0 = ferr_cnt;
        exp_q.push_back(8'h1C);
        send_bits(mk_frame(8'h1C, 1'b0, 1'b0), 10);
        @(negedge clk);
        ps2_dat = 1'b1;
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b0;
        repeat (FILTER_LEN + 1) @(posedge clk);
        #1 check("lat_before", code_valid, 1'b0);
        @(posedge clk);
        #1 check("lat_valid", code_valid, 1'b1);
        check("lat_code", code, 8'h1C);
        @(posedge clk);
        #1 check("lat_one_cycle", code_valid, 1'b0);
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b1;
        repeat (20) @(negedge clk);
        check("lat_perr", perr_cnt - p0, 0);
        check("lat_ferr", ferr_cnt - f0, 0);
        drain("lat_drain");

        for (int i = 0; i < 8; i++) begin
            p0 = perr_cnt; f0 = ferr_cnt;
            if (vecs[i].exp_good) exp_q.push_back(vecs[i].data);
            send_bits(mk_frame(vecs[i].data, vecs[i].bad_par, vecs[i].bad_stop), 11);
            repeat (20) @(negedge clk);
            check($sformatf("vec%0d_perr", i), perr_cnt - p0, vecs[i].exp_perr);
            check($sformatf("vec%0d_ferr", i), ferr_cnt - f0, vecs[i].exp_ferr);
            check($sformatf("vec%0d_busy", i), busy, 1'b0);
            drain($sformatf("vec%0d_drain", i));
        end

        // Overflow: fill with the consumer stalled; the 5th good byte is dropped.
        code_ready = 1'b0;
        o0 = ovf_cnt; p0 = perr_cnt; f0 = ferr_cnt;
        for (int i = 1; i <= 5; i++) begin
            if (exp_q.size() < FIFO_DEPTH) exp_q.push_back(8'(i));
            send_bits(mk_frame(8'(i), 1'b0, 1'b0), 11);
            repeat (20) @(negedge clk);
        end
        check("ovf_pulses", ovf_cnt - o0, 1);
        check("ovf_no_err", (perr_cnt - p0) + (ferr_cnt - f0), 0);
        check("ovf_head_valid", code_valid, 1'b1);
        check("ovf_head_code", code, 8'h01);
        repeat (10) @(negedge clk);
        check("ovf_head_stable", code, 8'h01);
        code_ready = 1'b1;
        drain("ovf_drain");
        @(negedge clk);
        check("ovf_empty", code_valid, 1'b0);

        // Timeout: start bit plus 3 data bits, then the clock stays high.
        f0 = ferr_cnt;
        send_bits(mk_frame(8'hAA, 1'b0, 1'b0), 4);
        repeat (100) @(negedge clk);
        check("tout_busy_mid", busy, 1'b1);
        n = 0;
        while (ferr_cnt == f0 && n < 3 * TIMEOUT) begin
            @(negedge clk);
            n++;
        end
        check("tout_ferr", ferr_cnt - f0, 1);
        check("tout_busy_after", busy, 1'b0);
        exp_q.push_back(8'hAA);
        send_bits(mk_frame(8'hAA, 1'b0, 1'b0), 11);
        repeat (20) @(negedge clk);
        drain("tout_next_frame");

        // Sub-filter glitches with data low must never look like a start bit.
        ps2_dat = 1'b0;
        for (int len = 1; len < FILTER_LEN; len++) begin
            busy_seen = 1'b0;
            @(negedge clk);
            ps2_clk = 1'b0;
            repeat (len) @(negedge clk);
            ps2_clk = 1'b1;
            for (int k = 0; k < 25; k++) begin
                @(negedge clk);
                busy_seen = busy_seen | busy;
            end
            check($sformatf("glitch%0d_busy", len), busy_seen, 1'b0);
        end
        ps2_dat = 1'b1;
        repeat (5) @(negedge clk);

        // Reset after the 4th data bit, then a full clean frame.
        p0 = perr_cnt; f0 = ferr_cnt;
        send_bits(mk_frame(8'hC3, 1'b0, 1'b0), 5);
        check("rstmid_busy_before", busy, 1'b1);
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("rstmid_busy", busy, 1'b0);
        check("rstmid_valid", code_valid, 1'b0);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        exp_q.push_back(8'h5A);
        send_bits(mk_frame(8'h5A, 1'b0, 1'b0), 11);
        repeat (20) @(negedge clk);
        drain("rstmid_drain");
        check("rstmid_errs", (perr_cnt - p0) + (ferr_cnt - f0), 0);

        repeat (10) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
